// File: rtl/serial_tagger_pkg.sv
// Shared helpers for the reorder crossbar: tag width derivation and DEPTH sanity checks.
package serial_tagger_pkg;

  localparam int DEFAULT_DEPTH = 16;

  function automatic int serial_width(input int depth);
    return $clog2(depth);
  endfunction

  // A valid window is a power of two so the tag counter wraps exactly at DEPTH.
  function automatic bit depth_is_pow2(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/serial_tagger_credit_window.sv
// Outstanding-beat counter with full flag and sticky underflow error; reusable by dispatchers.
module credit_window
  import serial_tagger_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = serial_width(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             err_underflow
);

  logic dec_eff;

  // A release with nothing outstanding is dropped so the count never wraps below zero.
  assign dec_eff = dec && (count != '0);
  assign full    = (count == CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= '0;
      err_underflow <= 1'b0;
    end else begin
      count         <= count + CNT_W'(inc) - CNT_W'(dec_eff);
      err_underflow <= err_underflow | (dec && (count == '0));
    end
  end

endmodule

// File: rtl/serial_tagger.sv
// Stamps each accepted beat with a wrapping serial tag; issue is throttled to DEPTH outstanding beats.
module serial_tagger
  import serial_tagger_pkg::*;
#(
  parameter type data_t       = logic [7:0],
  parameter int  KEEP_WIDTH   = 1,
  parameter int  DEPTH        = DEFAULT_DEPTH,
  parameter int  SERIAL_WIDTH = serial_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  // valid/ready: a beat transfers on any edge where valid && ready; once valid is
  // raised the producer holds all fields stable until that transfer happens.
  input  data_t                   in_data,
  input  logic [KEEP_WIDTH-1:0]   in_keep,
  input  logic                    in_last,
  input  logic                    in_valid,
  output logic                    in_ready,
  output data_t                   out_data,
  output logic [KEEP_WIDTH-1:0]   out_keep,
  output logic                    out_last,
  output logic [SERIAL_WIDTH-1:0] out_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    release_valid,
  output logic [SERIAL_WIDTH:0]   outstanding,
  output logic                    err_underflow
);

  if (!depth_is_pow2(DEPTH)) begin : g_bad_depth
    $error("serial_tagger: DEPTH must be a power of two >= 2");
  end

  logic                    full;
  logic                    accept;
  logic [SERIAL_WIDTH-1:0] next_tag;

  // in_ready uses registered state only, so a release frees a credit one cycle later.
  assign in_ready = !rst && !full && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  credit_window #(
    .DEPTH (DEPTH),
    .CNT_W (SERIAL_WIDTH + 1)
  ) u_credit_window (
    .clk           (clk),
    .rst           (rst),
    .inc           (accept),
    .dec           (release_valid),
    .count         (outstanding),
    .full          (full),
    .err_underflow (err_underflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      next_tag  <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      next_tag  <= next_tag + 1'b1;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Payload needs no reset: it is meaningless until out_valid rises.
  always_ff @(posedge clk) begin
    if (accept) begin
      out_data <= in_data;
      out_keep <= in_keep;
      out_last <= in_last;
      out_tag  <= next_tag;
    end
  end

endmodule

// File: tb/tb_serial_tagger.sv
// Directed bench for serial_tagger at DEPTH=4: credit window, backpressure, underflow, reset.
module tb_serial_tagger;

  localparam int DEPTH = 4;
  localparam int SW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic [0:0]    in_keep;
  logic          in_last;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    out_data;
  logic [0:0]    out_keep;
  logic          out_last;
  logic [SW-1:0] out_tag;
  logic          out_valid;
  logic          out_ready;
  logic          release_valid;
  logic [SW:0]   outstanding;
  logic          err_underflow;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_tagger #(
    .data_t       (logic [7:0]),
    .KEEP_WIDTH   (1),
    .DEPTH        (DEPTH),
    .SERIAL_WIDTH (SW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_keep       (in_keep),
    .in_last       (in_last),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_keep      (out_keep),
    .out_last      (out_last),
    .out_tag       (out_tag),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .release_valid (release_valid),
    .outstanding   (outstanding),
    .err_underflow (err_underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Inputs change on the falling edge; #1 lets combinational in_ready settle before checks.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_keep = 1'b1; in_last = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; release_valid = 1'b0;
    next_cycle(); next_cycle();
    #1;
    check("rst_out_valid",   32'(out_valid), 32'd0);
    check("rst_outstanding", 32'(outstanding), 32'd0);
    check("rst_err",         32'(err_underflow), 32'd0);
    check("rst_in_ready",    32'(in_ready), 32'd0);

    // Back-to-back stream, no releases: tags 0..3 then stall at a full window.
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h10;
    #1 check("in_ready_after_rst", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      #1;
      check($sformatf("b2b_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("b2b_tag%0d", i),   32'(out_tag), 32'(i));
      check($sformatf("b2b_data%0d", i),  32'(out_data), 32'(8'h10 + i));
      check($sformatf("b2b_outst%0d", i), 32'(outstanding), 32'(i + 1));
      in_data = 8'(8'h11 + i);
    end
    #1 check("full_in_ready", 32'(in_ready), 32'd0);
    next_cycle(); #1;
    check("stall_valid", 32'(out_valid), 32'd0);
    check("stall_outst", 32'(outstanding), 32'd4);
    next_cycle(); #1;
    check("stall2_in_ready", 32'(in_ready), 32'd0);

    // One release at a full window: credit appears only next cycle.
    release_valid = 1'b1;
    #1 check("release_cycle_in_ready", 32'(in_ready), 32'd0);
    next_cycle();
    release_valid = 1'b0;
    #1;
    check("after_release_in_ready", 32'(in_ready), 32'd1);
    check("after_release_outst",    32'(outstanding), 32'd3);
    next_cycle(); #1;
    check("beat5_valid", 32'(out_valid), 32'd1);
    check("beat5_tag",   32'(out_tag), 32'd0);
    check("beat5_data",  32'(out_data), 32'h14);
    check("beat5_outst", 32'(outstanding), 32'd4);

    // Drain two credits, then issue tag 1.
    in_valid = 1'b0; release_valid = 1'b1;
    next_cycle(); next_cycle();
    release_valid = 1'b0; in_valid = 1'b1; in_data = 8'h77;
    next_cycle(); #1;
    check("tag1_tag",   32'(out_tag), 32'd1);
    check("tag1_outst", 32'(outstanding), 32'd3);

    // Accept and release together at outstanding=3: count unchanged, tag advances.
    in_data = 8'hA5; in_last = 1'b1; in_keep = 1'b0; release_valid = 1'b1;
    #1 check("acc_rel_in_ready", 32'(in_ready), 32'd1);
    next_cycle();
    release_valid = 1'b0; out_ready = 1'b0; in_data = 8'hEE; in_last = 1'b0; in_keep = 1'b1;
    #1;
    check("acc_rel_outst", 32'(outstanding), 32'd3);
    check("bp_in_ready",   32'(in_ready), 32'd0);

    // Backpressure: hold tag 2 / 0xA5 stable for three cycles.
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bp_tag%0d", i),   32'(out_tag), 32'd2);
      check($sformatf("bp_data%0d", i),  32'(out_data), 32'hA5);
      check($sformatf("bp_last%0d", i),  32'(out_last), 32'd1);
      check($sformatf("bp_keep%0d", i),  32'(out_keep), 32'd0);
      next_cycle(); #1;
    end
    check("bp_outst", 32'(outstanding), 32'd3);
    out_ready = 1'b1; in_valid = 1'b0;
    next_cycle(); #1;
    check("bp_single_transfer", 32'(out_valid), 32'd0);

    // Release down to zero, then one extra release to trip underflow.
    release_valid = 1'b1;
    next_cycle(); next_cycle(); next_cycle(); #1;
    check("drained_outst",   32'(outstanding), 32'd0);
    check("pre_underflow",   32'(err_underflow), 32'd0);
    next_cycle();
    release_valid = 1'b0;
    #1;
    check("underflow_outst", 32'(outstanding), 32'd0);
    check("underflow_set",   32'(err_underflow), 32'd1);
    next_cycle(); #1;
    check("underflow_sticky", 32'(err_underflow), 32'd1);

    // Tags continue across last; then a mid-stream reset restarts at tag 0.
    in_valid = 1'b1; in_data = 8'h31; out_ready = 1'b0;
    next_cycle();
    in_valid = 1'b0;
    #1;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_tag",   32'(out_tag), 32'd3);
    rst = 1'b1;
    #1 check("rst_high_in_ready", 32'(in_ready), 32'd0);
    next_cycle();
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_outst", 32'(outstanding), 32'd0);
    check("mid_rst_err",   32'(err_underflow), 32'd0);
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h42;
    next_cycle();
    in_valid = 1'b0;
    #1;
    check("post_rst_tag",   32'(out_tag), 32'd0);
    check("post_rst_data",  32'(out_data), 32'h42);
    check("post_rst_outst", 32'(outstanding), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_tagger.md
Name: serial_tagger

Overview:
- Issue side of the reorder scheme: accepts an in-order data stream and stamps each beat with a monotonically increasing serial number (mod 2^SERIAL_WIDTH) as its tag.
- Output feeds a dispatcher or parallel units that may complete out of order; the downstream Reorder block restores order by tag.
- Enforces a window of at most DEPTH outstanding beats using a release pulse from the reorder output, so no two in-flight beats share a tag.

Parameters:
- data_t, (none), payload type carried on in/out.
- DEPTH, 16, max outstanding beats; must equal the downstream Reorder DEPTH; must be a power of two ≥ 2.
- SERIAL_WIDTH, $clog2(DEPTH), tag width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in  data_i.s #(data_t)  -  in-order input stream: data, keep, last, valid, ready.
- out  tagged_i.m #(data_t, SERIAL_WIDTH)  -  tagged output: data, keep, last, tag, valid, ready.
- release_valid  input  1  one beat retired downstream this cycle; drive from the Reorder out.valid && out.ready.
- outstanding  output  SERIAL_WIDTH+1  registered count of issued-but-unreleased beats, 0..DEPTH.
- err_underflow  output  1  sticky; set when release_valid arrives with outstanding == 0.

Behaviour:
- Reset (rst high at a clk edge): next_tag=0, outstanding=0, out.valid=0, err_underflow=0. While rst is high, in.ready=0. out.data/keep/last/tag are don't-care until the first valid.
- Reset mid-operation discards all in-flight state. The downstream Reorder must be reset in the same cycle.
- in.ready = !rst && (outstanding < DEPTH) && (!out.valid || out.ready). It is combinational from registered state only; there is no path from release_valid to in.ready.
- Accept = in.valid && in.ready. On accept, the next edge does:
  - out.data/keep/last <= in.data/keep/last
  - out.tag <= next_tag
  - out.valid <= 1
  - next_tag <= next_tag + 1 (wraps DEPTH-1 → 0)
- Latency is 1 cycle from input handshake to out.valid. Throughput is 1 beat/cycle while credits remain.
- If out.ready && !accept, then out.valid <= 0.
- If out.valid && !out.ready, all out fields hold stable (AXI-stream rule). No beat is dropped or duplicated.
- Counter update: outstanding <= outstanding + accept - (release_valid && outstanding != 0). Width is SERIAL_WIDTH+1, so DEPTH is representable.
- Simultaneous accept and release leaves the count unchanged.
- Release at outstanding == DEPTH frees a credit visible the following cycle. in.ready stays low in the release cycle.
- Release at outstanding == 0 is ignored (count stays 0) and sets err_underflow. err_underflow clears only on rst.
- last and keep pass through untouched. Tags ignore packet boundaries, so the serial continues across last.
- Invariant: the tags of unreleased beats are always distinct, because outstanding ≤ DEPTH = 2^SERIAL_WIDTH.

Decomposition:
- Shared crossbar package:
  - function serial_width(depth) returning $clog2(depth).
  - compile-time assertion helper checking that DEPTH is a power of two.
- One natural sub-module: credit_window (outstanding counter, full flag, underflow flag). Reused by future dispatchers.
- Output register and tag counter stay in serial_tagger.

Test Plan:
- DEPTH=4, reset, 6 back-to-back input beats, out.ready=1, no releases -> tags 0,1,2,3 emitted on cycles 1-4; in.ready low after the 4th accept; beats 5-6 stall; outstanding=4.
- From that state, one release_valid pulse at cycle t -> in.ready high at t+1; beat 5 emitted with tag 0 at t+2; outstanding returns to 4.
- out.ready held low for 3 cycles with beat tag=2, data=0xA5 on out -> out holds tag=2/data=0xA5 stable; in.ready=0; on out.ready=1 exactly one transfer occurs.
- outstanding=3, accept and release_valid in the same cycle -> outstanding stays 3; next tag increments by 1.
- release_valid with outstanding=0 -> outstanding stays 0; err_underflow=1 next cycle and remains set until rst.
- rst asserted for 1 cycle mid-stream with out.valid=1 -> out.valid=0, outstanding=0, next emitted tag=0.
